// File: rtl/sap1_pkg.sv
// Shared SAP-1 RAM geometry and the program-controller state encoding.
package sap1_pkg;

  localparam int SAP1_ADDR_W = 4;
  localparam int SAP1_DATA_W = 8;

  typedef enum logic [2:0] {
    RUN   = 3'd0,
    IDLE  = 3'd1,
    SETUP = 3'd2,
    WRITE = 3'd3,
    HOLD  = 3'd4,
    DONE  = 3'd5
  } ram_prog_state_t;

endpackage

// File: rtl/ram_prog_strobe_timer.sv
// Counts the clocks the RAM write strobe has been high and flags the last one,
// so the controller leaves WRITE after exactly WRITE_CYCLES clocks.
module ram_prog_strobe_timer #(
  parameter int WRITE_CYCLES = 1
) (
  input  logic clk,
  input  logic rst,
  input  logic active_i,
  output logic last_o
);

  logic [3:0] cnt_q;

  assign last_o = active_i && (cnt_q == 4'(WRITE_CYCLES - 1));

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt_q <= '0;
    end else if (active_i && !last_o) begin
      cnt_q <= cnt_q + 4'd1;
    end else begin
      cnt_q <= '0;
    end
  end

endmodule

// File: rtl/ram_prog_ctrl.sv
// Owns the SAP-1 program/data RAM: passes CPU reads through in run mode and
// streams loader bytes into consecutive words with a setup/strobe/hold write.
module ram_prog_ctrl
  import sap1_pkg::*;
#(
  parameter int ADDR_W       = SAP1_ADDR_W,
  parameter int DATA_W       = SAP1_DATA_W,
  parameter int WRITE_CYCLES = 1
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              prog_mode,
  input  logic [DATA_W-1:0] in_data,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [ADDR_W-1:0] cpu_addr,
  input  logic              cpu_ce,
  output logic              cpu_wait,
  output logic [ADDR_W-1:0] ram_addr,
  output logic [DATA_W-1:0] ram_data_in,
  output logic              ram_ce,
  output logic              ram_leitura_escrita,
  output logic              ram_run_prog,
  output logic [ADDR_W:0]   words_loaded,
  output logic              prog_done,
  output logic [2:0]        state_dbg
);

  localparam int DEPTH = 2 ** ADDR_W;
  localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(DEPTH - 1);
  localparam logic [ADDR_W:0]   FULL_CNT  = (ADDR_W + 1)'(DEPTH);

  ram_prog_state_t   state_q;
  logic              mode_q;
  logic [ADDR_W-1:0] ptr_q;
  logic [DATA_W-1:0] data_q;
  logic [ADDR_W:0]   words_q;
  logic              strobe_last;
  logic              write_phase;
  logic              run_state;

  ram_prog_strobe_timer #(
    .WRITE_CYCLES(WRITE_CYCLES)
  ) u_strobe_timer (
    .clk     (clk),
    .rst     (rst),
    .active_i(state_q == WRITE),
    .last_o  (strobe_last)
  );

  // Valid/ready: a byte transfers on a rising edge where in_valid and
  // in_ready are both high; in_ready is only high in IDLE and never depends
  // on in_valid, and the byte is latched into data_q on that edge.
  assign run_state   = (state_q == RUN);
  assign write_phase = (state_q == SETUP) || (state_q == WRITE) || (state_q == HOLD);

  // Outputs decode the registered state; the RUN path is gated by reset so the
  // RAM sees no CPU access while rst is asserted.
  assign in_ready            = (state_q == IDLE);
  assign prog_done           = (state_q == DONE);
  assign cpu_wait            = !run_state;
  assign ram_addr            = run_state ? (rst ? '0 : cpu_addr) : ptr_q;
  assign ram_ce              = run_state ? (cpu_ce && !rst) : write_phase;
  assign ram_leitura_escrita = !write_phase;
  assign ram_run_prog        = (state_q == WRITE);
  assign ram_data_in         = data_q;
  assign words_loaded        = words_q;
  assign state_dbg           = state_q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= RUN;
      mode_q  <= 1'b0;
      ptr_q   <= '0;
      data_q  <= '0;
      words_q <= '0;
    end else begin
      mode_q <= prog_mode;
      case (state_q)
        RUN: begin
          if (mode_q) begin
            state_q <= IDLE;
            ptr_q   <= '0;
            words_q <= '0;
          end
        end
        IDLE: begin
          if (!mode_q) begin
            state_q <= RUN;
          end else if (in_valid) begin
            data_q  <= in_data;
            state_q <= SETUP;
          end
        end
        SETUP: state_q <= WRITE;
        WRITE: begin
          if (strobe_last) state_q <= HOLD;
        end
        HOLD: begin
          // A mode drop here still counts the word; it only changes the exit.
          if (words_q != FULL_CNT) words_q <= words_q + 1'b1;
          if (ptr_q != LAST_ADDR) ptr_q <= ptr_q + 1'b1;
          if (!mode_q) begin
            state_q <= RUN;
          end else if (ptr_q == LAST_ADDR) begin
            state_q <= DONE;
          end else begin
            state_q <= IDLE;
          end
        end
        DONE: begin
          if (!mode_q) state_q <= RUN;
        end
        default: state_q <= RUN;
      endcase
    end
  end

endmodule

// File: tb/tb_ram_prog_ctrl.sv
// Directed bench for ram_prog_ctrl: behavioural RAM models behind two
// controllers (1- and 3-clock strobes) plus a write scoreboard.
module tb_ram_prog_ctrl;

  logic       clk = 1'b0;
  logic       rst;
  logic [3:0] cpu_addr;
  logic       cpu_ce;

  logic       prog_mode1, in_valid1, in_ready1, cpu_wait1;
  logic [7:0] in_data1, ram_data1;
  logic [3:0] ram_addr1;
  logic       ram_ce1, ram_le1, ram_rp1, prog_done1;
  logic [4:0] words1;
  logic [2:0] state1;

  logic       prog_mode3, in_valid3, in_ready3, cpu_wait3;
  logic [7:0] in_data3, ram_data3;
  logic [3:0] ram_addr3;
  logic       ram_ce3, ram_le3, ram_rp3, prog_done3;
  logic [4:0] words3;
  logic [2:0] state3;

  logic [7:0]  mem1 [16];
  logic [7:0]  mem3 [16];
  logic [11:0] exp_q [$];
  logic [3:0]  addr_model;
  int n_checks = 0;
  int n_errors = 0;
  int cyc = 0;

  always #5 clk = ~clk;
  always @(posedge clk) cyc++;

  ram_prog_ctrl #(.WRITE_CYCLES(1)) dut1 (
    .clk(clk), .rst(rst), .prog_mode(prog_mode1), .in_data(in_data1),
    .in_valid(in_valid1), .in_ready(in_ready1), .cpu_addr(cpu_addr),
    .cpu_ce(cpu_ce), .cpu_wait(cpu_wait1), .ram_addr(ram_addr1),
    .ram_data_in(ram_data1), .ram_ce(ram_ce1), .ram_leitura_escrita(ram_le1),
    .ram_run_prog(ram_rp1), .words_loaded(words1), .prog_done(prog_done1),
    .state_dbg(state1)
  );

  ram_prog_ctrl #(.WRITE_CYCLES(3)) dut3 (
    .clk(clk), .rst(rst), .prog_mode(prog_mode3), .in_data(in_data3),
    .in_valid(in_valid3), .in_ready(in_ready3), .cpu_addr(cpu_addr),
    .cpu_ce(cpu_ce), .cpu_wait(cpu_wait3), .ram_addr(ram_addr3),
    .ram_data_in(ram_data3), .ram_ce(ram_ce3), .ram_leitura_escrita(ram_le3),
    .ram_run_prog(ram_rp3), .words_loaded(words3), .prog_done(prog_done3),
    .state_dbg(state3)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // RAM models, write-window stability, strobe length and the write scoreboard.
  logic       win1 = 1'b0, win3 = 1'b0;
  logic [3:0] wa1, wa3;
  logic [7:0] wd1, wd3;
  int         hi1, hi3;

  always @(negedge clk) begin
    if (!rst && ram_rp1) begin
      check("strobe_qual1", 32'({ram_ce1, ram_le1}), 32'h2);
      mem1[ram_addr1] = ram_data1;
      if (exp_q.size() == 0) begin
        check("sb_underflow", 32'(exp_q.size()), 32'd1);
      end else begin
        check("sb_write", 32'({ram_addr1, ram_data1}), 32'(exp_q.pop_front()));
      end
    end
    if (!rst && cpu_wait1 && ram_ce1) check("no_cpu_read1", 32'(ram_le1), 32'd0);
    if (!rst && ram_ce1 && !ram_le1) begin
      if (!win1) begin
        win1 = 1'b1; wa1 = ram_addr1; wd1 = ram_data1; hi1 = 0;
      end else begin
        check("stable_addr1", 32'(ram_addr1), 32'(wa1));
        check("stable_data1", 32'(ram_data1), 32'(wd1));
      end
      if (ram_rp1) hi1++;
    end else if (win1) begin
      win1 = 1'b0;
      if (!rst) check("strobe_len1", 32'(hi1), 32'd1);
    end
  end

  always @(negedge clk) begin
    if (!rst && ram_rp3) begin
      check("strobe_qual3", 32'({ram_ce3, ram_le3}), 32'h2);
      mem3[ram_addr3] = ram_data3;
    end
    if (!rst && ram_ce3 && !ram_le3) begin
      if (!win3) begin
        win3 = 1'b1; wa3 = ram_addr3; wd3 = ram_data3; hi3 = 0;
      end else begin
        check("stable_addr3", 32'(ram_addr3), 32'(wa3));
        check("stable_data3", 32'(ram_data3), 32'(wd3));
      end
      if (ram_rp3) hi3++;
    end else if (win3) begin
      win3 = 1'b0;
      if (!rst) check("strobe_len3", 32'(hi3), 32'd3);
    end
  end

  // Offer one byte to the selected controller; returns at posedge+1 after the
  // handshake, leaving in_valid asserted.
  task automatic send(input bit sel3, input logic [7:0] d, output int acc_cyc);
    logic rdy;
    rdy = 1'b0;
    if (sel3) begin in_data3 = d; in_valid3 = 1'b1; end
    else begin in_data1 = d; in_valid1 = 1'b1; end
    for (int k = 0; k < 50; k++) begin
      @(negedge clk);
      rdy = sel3 ? in_ready3 : in_ready1;
      if (rdy) break;
    end
    acc_cyc = cyc;
    if (!rdy) begin
      check("accept_timeout", 32'(rdy), 32'd1);
    end else if (!sel3) begin
      exp_q.push_back({addr_model, d});
      addr_model = addr_model + 4'd1;
    end
    @(posedge clk);
    #1;
  endtask

  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  initial begin
    int acc, prev;
    for (int i = 0; i < 16; i++) begin mem1[i] = 8'h00; mem3[i] = 8'h00; end
    rst = 1'b1; cpu_addr = 4'd3; cpu_ce = 1'b1; addr_model = 4'd0;
    prog_mode1 = 1'b0; in_valid1 = 1'b0; in_data1 = 8'h00;
    prog_mode3 = 1'b0; in_valid3 = 1'b0; in_data3 = 8'h00;
    tick(3);
    check("rst_ram_ce", 32'(ram_ce1), 32'd0);
    check("rst_ram_le", 32'(ram_le1), 32'd1);
    check("rst_ram_addr", 32'(ram_addr1), 32'd0);
    check("rst_ram_data", 32'(ram_data1), 32'd0);
    check("rst_in_ready", 32'(in_ready1), 32'd0);
    check("rst_cpu_wait", 32'(cpu_wait1), 32'd0);
    rst = 1'b0;
    #1;
    check("run_addr", 32'(ram_addr1), 32'd3);
    check("run_ce", 32'(ram_ce1), 32'd1);
    check("run_le", 32'(ram_le1), 32'd1);
    tick(2);
    rst = 1'b1;
    #1;
    check("rst_mid_run_ce", 32'(ram_ce1), 32'd0);
    check("rst_mid_run_rp", 32'(ram_rp1), 32'd0);
    check("rst_mid_run_words", 32'(words1), 32'd0);
    tick(1);
    rst = 1'b0;

    // Full load with in_valid held high; cpu_ce stays requested throughout.
    prog_mode1 = 1'b1; addr_model = 4'd0; prev = 0;
    for (int i = 0; i < 16; i++) begin
      send(1'b0, 8'h10 + 8'(i), acc);
      if (i == 1) check("cpu_wait_prog", 32'(cpu_wait1), 32'd1);
      if (i > 0) check("accept_period1", 32'(acc - prev), 32'd4);
      prev = acc;
    end
    in_data1 = 8'hEE;
    for (int k = 0; k < 8; k++) begin
      @(negedge clk);
      check("byte17_ready", 32'(in_ready1), 32'd0);
    end
    in_valid1 = 1'b0;
    check("full_done", 32'(prog_done1), 32'd1);
    check("full_words", 32'(words1), 32'd16);
    check("full_sb_empty", 32'(exp_q.size()), 32'd0);
    for (int i = 0; i < 16; i++) check("full_mem", 32'(mem1[i]), 32'h10 + 32'(i));
    #1;
    prog_mode1 = 1'b0;
    tick(2);
    check("back_run_wait", 32'(cpu_wait1), 32'd0);
    check("back_run_addr", 32'(ram_addr1), 32'd3);
    check("back_run_ce", 32'(ram_ce1), 32'd1);
    check("back_run_done", 32'(prog_done1), 32'd0);
    check("back_run_words", 32'(words1), 32'd16);

    // Abort: mode drops while byte 5 (0xA5) is in WRITE.
    prog_mode1 = 1'b1; addr_model = 4'd0;
    for (int i = 0; i < 6; i++) send(1'b0, 8'hA0 + 8'(i), acc);
    tick(1);
    check("abort_in_write", 32'(ram_rp1), 32'd1);
    prog_mode1 = 1'b0; in_valid1 = 1'b0;
    tick(4);
    check("abort_words", 32'(words1), 32'd6);
    check("abort_run", 32'(cpu_wait1), 32'd0);
    check("abort_sb_empty", 32'(exp_q.size()), 32'd0);
    for (int i = 0; i < 6; i++) check("abort_mem_new", 32'(mem1[i]), 32'hA0 + 32'(i));
    for (int i = 6; i < 16; i++) check("abort_mem_old", 32'(mem1[i]), 32'h10 + 32'(i));

    // Random gaps in in_valid over a fresh load of the same image.
    for (int i = 0; i < 16; i++) mem1[i] = 8'h00;
    prog_mode1 = 1'b1; addr_model = 4'd0;
    for (int i = 0; i < 16; i++) begin
      if ($urandom_range(0, 99) < 50) begin
        in_valid1 = 1'b0;
        in_data1 = 8'($urandom_range(0, 255));
        tick($urandom_range(1, 4));
      end
      send(1'b0, 8'h10 + 8'(i), acc);
    end
    in_valid1 = 1'b0;
    tick(6);
    check("gap_done", 32'(prog_done1), 32'd1);
    check("gap_words", 32'(words1), 32'd16);
    check("gap_sb_empty", 32'(exp_q.size()), 32'd0);
    for (int i = 0; i < 16; i++) check("gap_mem", 32'(mem1[i]), 32'h10 + 32'(i));
    prog_mode1 = 1'b0;
    tick(2);

    // Three-clock strobe on the second controller.
    prog_mode3 = 1'b1; prev = 0;
    for (int i = 0; i < 4; i++) begin
      send(1'b1, 8'h30 + 8'(i), acc);
      if (i > 0) check("accept_period3", 32'(acc - prev), 32'd6);
      prev = acc;
    end
    in_valid3 = 1'b0;
    tick(8);
    check("strobe_words3", 32'(words3), 32'd4);
    for (int i = 0; i < 4; i++) check("strobe_mem3", 32'(mem3[i]), 32'h30 + 32'(i));
    prog_mode3 = 1'b0;
    tick(2);

    // Reset while the strobe is high drops it immediately.
    prog_mode1 = 1'b1; addr_model = 4'd0;
    send(1'b0, 8'h55, acc);
    in_valid1 = 1'b0;
    tick(1);
    check("pre_rst_rp", 32'(ram_rp1), 32'd1);
    rst = 1'b1;
    #1;
    check("rst_write_rp", 32'(ram_rp1), 32'd0);
    check("rst_write_ce", 32'(ram_ce1), 32'd0);
    check("rst_write_le", 32'(ram_le1), 32'd1);
    check("rst_write_ready", 32'(in_ready1), 32'd0);
    check("rst_write_wait", 32'(cpu_wait1), 32'd0);
    check("rst_write_words", 32'(words1), 32'd0);
    exp_q.delete();
    prog_mode1 = 1'b0;
    tick(2);
    rst = 1'b0;
    tick(2);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: observed timeout expected finish");
    $fatal(1, "watchdog expired");
  end

endmodule
